// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: port addressing and the packet-sequencing state set.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_PORT0   = 2'b00;
    localparam logic [ADDR_W-1:0] ADDR_PORT1   = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_PORT2   = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    // Picks one per-port flag by address; the invalid address never selects anything.
    function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                      input logic [ADDR_W-1:0]    addr);
        logic sel;
        case (addr)
            ADDR_PORT0: sel = vec[0];
            ADDR_PORT1: sel = vec[1];
            ADDR_PORT2: sel = vec[2];
            default:    sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing controller for the 1x3 router: header decode, byte load strobes,
// source throttling, and packet abort on destination soft reset or drain timeout.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a valid header
// LOAD_FIRST_DATA    | header byte written to the FIFO
// LOAD_DATA          | payload bytes streaming
// FIFO_FULL_STATE    | destination full, source held
// LOAD_AFTER_FULL    | byte held during full is written
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | internal parity registers cleared
// WAIT_TILL_EMPTY    | destination still draining a previous packet
module router_fsm_ctrl
    import router_pkg::*;
#(
    parameter int WAIT_MAX = 63,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_rst_0,
    input  logic              soft_rst_1,
    input  logic              soft_rst_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              write_en_reg,
    output logic              ld_state,
    output logic              lfd_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_pkt
);

    router_state_t     state;
    router_state_t     state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic [NUM_PORTS-1:0] empty_vec;
    logic [NUM_PORTS-1:0] soft_vec;
    logic                 header_ok;
    logic                 empty_hdr;
    logic                 empty_sel;
    logic                 soft_sel;
    logic                 wait_done;
    logic                 drop_nxt;
    logic                 addr_ld;

    assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec  = {soft_rst_2, soft_rst_1, soft_rst_0};

    assign header_ok = pkt_valid && (data_in != ADDR_INVALID);
    assign empty_hdr = port_bit(empty_vec, data_in);
    assign empty_sel = port_bit(empty_vec, addr_q);
    assign soft_sel  = port_bit(soft_vec, addr_q);
    assign wait_done = (wait_cnt == CNT_W'(WAIT_MAX - 1));
    assign addr_ld   = (state == DECODE_ADDRESS) && header_ok;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state    <= DECODE_ADDRESS;
            addr_q   <= ADDR_PORT0;
            wait_cnt <= '0;
            drop_pkt <= 1'b0;
        end else begin
            state    <= state_nxt;
            drop_pkt <= drop_nxt;
            if (addr_ld) begin
                addr_q <= data_in;
            end
            // Cleared on every accepted header so a fresh wait always starts from zero.
            if (addr_ld) begin
                wait_cnt <= '0;
            end else if ((state == WAIT_TILL_EMPTY) && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        // A soft reset on the addressed port aborts whatever the packet was doing.
        if ((state != DECODE_ADDRESS) && soft_sel) begin
            state_nxt = DECODE_ADDRESS;
            drop_nxt  = 1'b1;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (header_ok) begin
                        state_nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_nxt = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_nxt = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_nxt = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_nxt = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_nxt = LOAD_PARITY;
                    end else begin
                        state_nxt = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_sel) begin
                        state_nxt = LOAD_FIRST_DATA;
                    end else if (wait_done) begin
                        state_nxt = DECODE_ADDRESS;
                        drop_nxt  = 1'b1;
                    end
                end
                default: state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add   = 1'b0;
        write_en_reg = 1'b0;
        ld_state     = 1'b0;
        lfd_state    = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
        busy         = 1'b0;
        case (state)
            DECODE_ADDRESS: detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state     = 1'b1;
                write_en_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state    = 1'b1;
                write_en_reg = 1'b1;
                busy         = 1'b1;
            end
            LOAD_PARITY: begin
                write_en_reg = 1'b1;
                busy         = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default: detect_add = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: two instances (default and short drain timeout) share stimulus
// and are checked every cycle against a packet-level model of the controller.
module tb_router_fsm_ctrl;

    localparam int LIM_A = 63;
    localparam int LIM_B = 8;

    localparam int P_DEC    = 100;
    localparam int P_HDR    = 101;
    localparam int P_BODY   = 102;
    localparam int P_STALL  = 103;
    localparam int P_RESUME = 104;
    localparam int P_PAR    = 105;
    localparam int P_CHK    = 106;
    localparam int P_WAIT   = 107;

    typedef struct {
        int ph;
        int waited;
        int port;
        bit drop;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
    logic       parity_done, low_pkt_valid;

    logic detect_add_a, write_en_reg_a, ld_state_a, lfd_state_a, laf_state_a;
    logic full_state_a, rst_int_reg_a, busy_a, drop_pkt_a;
    logic detect_add_b, write_en_reg_b, ld_state_b, lfd_state_b, laf_state_b;
    logic full_state_b, rst_int_reg_b, busy_b, drop_pkt_b;
    logic [8:0] outs_a, outs_b;

    int vectors = 0;
    int miscompares = 0;

    mstate_t m_a, m_b;

    always #5 clk = ~clk;

    router_fsm_ctrl #(.WAIT_MAX(LIM_A), .CNT_W(8)) dut_a (
        .clk(clk), .reset_in(reset_in), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
        .soft_rst_2(soft_rst_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add_a), .write_en_reg(write_en_reg_a), .ld_state(ld_state_a),
        .lfd_state(lfd_state_a), .laf_state(laf_state_a), .full_state(full_state_a),
        .rst_int_reg(rst_int_reg_a), .busy(busy_a), .drop_pkt(drop_pkt_a)
    );

    router_fsm_ctrl #(.WAIT_MAX(LIM_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset_in(reset_in), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
        .soft_rst_2(soft_rst_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add_b), .write_en_reg(write_en_reg_b), .ld_state(ld_state_b),
        .lfd_state(lfd_state_b), .laf_state(laf_state_b), .full_state(full_state_b),
        .rst_int_reg(rst_int_reg_b), .busy(busy_b), .drop_pkt(drop_pkt_b)
    );

    assign outs_a = {detect_add_a, write_en_reg_a, ld_state_a, lfd_state_a, laf_state_a,
                     full_state_a, rst_int_reg_a, busy_a, drop_pkt_a};
    assign outs_b = {detect_add_b, write_en_reg_b, ld_state_b, lfd_state_b, laf_state_b,
                     full_state_b, rst_int_reg_b, busy_b, drop_pkt_b};

    // Packet-level model: one step per clock, waited counts whole cycles spent draining.
    function automatic mstate_t next_model(input mstate_t s, input int limit);
        mstate_t n;
        bit emp[3];
        bit sft[3];
        int hdr;
        n = s;
        n.drop = 1'b0;
        emp[0] = fifo_empty_0; emp[1] = fifo_empty_1; emp[2] = fifo_empty_2;
        sft[0] = soft_rst_0;   sft[1] = soft_rst_1;   sft[2] = soft_rst_2;
        hdr = int'(data_in);
        if (s.ph != P_DEC && sft[s.port]) begin
            n.ph = P_DEC;
            n.drop = 1'b1;
        end else begin
            case (s.ph)
                P_DEC: if (pkt_valid && hdr < 3) begin
                    n.port = hdr;
                    n.waited = 0;
                    n.ph = emp[hdr] ? P_HDR : P_WAIT;
                end
                P_HDR:    n.ph = P_BODY;
                P_BODY:   n.ph = fifo_full ? P_STALL : (!pkt_valid ? P_PAR : P_BODY);
                P_STALL:  n.ph = fifo_full ? P_STALL : P_RESUME;
                P_RESUME: n.ph = parity_done ? P_DEC : (low_pkt_valid ? P_PAR : P_BODY);
                P_PAR:    n.ph = P_CHK;
                P_CHK:    n.ph = fifo_full ? P_STALL : P_DEC;
                P_WAIT: begin
                    n.waited = s.waited + 1;
                    if (emp[s.port]) n.ph = P_HDR;
                    else if (n.waited >= limit) begin
                        n.ph = P_DEC;
                        n.drop = 1'b1;
                    end
                end
                default: n.ph = P_DEC;
            endcase
        end
        return n;
    endfunction

    // {detect_add, write_en_reg, ld, lfd, laf, full, rst_int, busy, drop_pkt}
    function automatic logic [8:0] exp_out(input mstate_t s);
        logic [7:0] v;
        case (s.ph)
            P_DEC:    v = 8'b1000_0000;
            P_HDR:    v = 8'b0001_0001;
            P_BODY:   v = 8'b0110_0000;
            P_STALL:  v = 8'b0000_0101;
            P_RESUME: v = 8'b0100_1001;
            P_PAR:    v = 8'b0100_0001;
            P_CHK:    v = 8'b0000_0011;
            P_WAIT:   v = 8'b0000_0001;
            default:  v = 8'bxxxx_xxxx;
        endcase
        return {v, s.drop};
    endfunction

    always @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            m_a <= '{ph: P_DEC, waited: 0, port: 0, drop: 1'b0};
            m_b <= '{ph: P_DEC, waited: 0, port: 0, drop: 1'b0};
        end else begin
            m_a <= next_model(m_a, LIM_A);
            m_b <= next_model(m_b, LIM_B);
        end
    end

    task automatic idle_inputs();
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_rst_0 = 1'b0; soft_rst_1 = 1'b0; soft_rst_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        vectors++;
        if ({outs_a, outs_b} !== {2{9'b1_0000_0000}}) begin
            miscompares++;
            $display("FAIL reset got=%b_%b exp=%b_%b", outs_a, outs_b, 9'b1_0000_0000, 9'b1_0000_0000);
        end
        reset_in = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
            miscompares++;
            $display("FAIL reset_idle got=%b_%b exp=%b_%b", outs_a, outs_b, exp_out(m_a), exp_out(m_b));
        end
    endtask

    task automatic test_basic();
        int nbusy = 0;
        idle_inputs();
        for (int c = 1; c <= 7; c++) begin
            pkt_valid = (c <= 4);
            data_in = 2'd1;
            @(posedge clk); #1;
            if (busy_a) nbusy++;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL basic cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
        vectors++;
        if (nbusy !== 3) begin
            miscompares++;
            $display("FAIL basic_busy_cycles got=%0d exp=3", nbusy);
        end
    endtask

    task automatic test_full_midpacket();
        int nfull = 0;
        int nwe_in_full = 0;
        idle_inputs();
        for (int c = 1; c <= 12; c++) begin
            pkt_valid = (c <= 9);
            data_in = 2'd0;
            fifo_full = (c >= 4 && c <= 7);
            @(posedge clk); #1;
            if (full_state_a) nfull++;
            if (full_state_a && write_en_reg_a) nwe_in_full++;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL full_mid cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
        vectors++;
        if (nfull !== 4 || nwe_in_full !== 0) begin
            miscompares++;
            $display("FAIL full_hold got=%0d/%0d exp=4/0", nfull, nwe_in_full);
        end
    endtask

    task automatic test_low_pkt_valid();
        idle_inputs();
        for (int c = 1; c <= 8; c++) begin
            pkt_valid = (c <= 3);
            data_in = 2'd2;
            fifo_full = (c == 3 || c == 4);
            low_pkt_valid = (c == 6);
            @(posedge clk); #1;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL low_pkt cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
    endtask

    task automatic test_wait_empty();
        int nbusy = 0;
        int ndrop = 0;
        idle_inputs();
        for (int c = 1; c <= 16; c++) begin
            pkt_valid = (c <= 12);
            data_in = 2'd2;
            fifo_empty_2 = (c >= 11);
            @(posedge clk); #1;
            if (c <= 10 && busy_a) nbusy++;
            if (drop_pkt_a) ndrop++;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL wait cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
        vectors++;
        if (nbusy !== 10 || ndrop !== 0) begin
            miscompares++;
            $display("FAIL wait_busy_drop got=%0d/%0d exp=10/0", nbusy, ndrop);
        end
    endtask

    task automatic test_timeout();
        int drops_a = 0;
        int drops_b = 0;
        int first_b = 0;
        idle_inputs();
        fifo_empty_0 = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            pkt_valid = (c == 1);
            data_in = 2'd0;
            @(posedge clk); #1;
            if (drop_pkt_a) drops_a++;
            if (drop_pkt_b) begin
                drops_b++;
                if (first_b == 0) first_b = c;
            end
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL timeout cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
        vectors++;
        if (drops_a !== 1 || drops_b !== 1 || first_b !== LIM_B + 1) begin
            miscompares++;
            $display("FAIL timeout_drops got=%0d/%0d@%0d exp=1/1@%0d", drops_a, drops_b, first_b, LIM_B + 1);
        end
    endtask

    task automatic test_soft_reset();
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            pkt_valid = 1'b1;
            data_in = 2'd0;
            soft_rst_1 = (c == 3);
            soft_rst_0 = (c == 4);
            @(posedge clk); #1;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL soft_rst cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
            if (c == 4) begin
                vectors++;
                if (outs_a !== 9'b1_0000_0001) begin
                    miscompares++;
                    $display("FAIL soft_rst_drop got=%b exp=%b", outs_a, 9'b1_0000_0001);
                end
            end
        end
        idle_inputs();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL soft_rst_tail cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
    endtask

    task automatic test_invalid_addr();
        idle_inputs();
        for (int c = 1; c <= 5; c++) begin
            pkt_valid = 1'b1;
            data_in = 2'd3;
            fifo_empty_0 = c[0];
            @(posedge clk); #1;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)} || outs_a !== 9'b1_0000_0000) begin
                miscompares++;
                $display("FAIL invalid_addr cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
    endtask

    task automatic test_async_reset_mid();
        idle_inputs();
        pkt_valid = 1'b1;
        data_in = 2'd1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (ld_state_a !== 1'b1) begin
            miscompares++;
            $display("FAIL async_setup got=%b exp=1", ld_state_a);
        end
        #2 reset_in = 1'b0;
        #1;
        vectors++;
        if ({outs_a, outs_b} !== {2{9'b1_0000_0000}}) begin
            miscompares++;
            $display("FAIL async_reset got=%b_%b exp=%b", outs_a, outs_b, 9'b1_0000_0000);
        end
        @(posedge clk); #1;
        reset_in = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        vectors++;
        if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
            miscompares++;
            $display("FAIL async_release got=%b_%b exp=%b_%b", outs_a, outs_b, exp_out(m_a), exp_out(m_b));
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3000; c++) begin
            pkt_valid     = ($urandom_range(0, 4) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 4) == 0);
            fifo_empty_0  = $urandom_range(0, 1) == 1;
            fifo_empty_1  = $urandom_range(0, 1) == 1;
            fifo_empty_2  = ($urandom_range(0, 7) == 0);
            soft_rst_0    = ($urandom_range(0, 40) == 0);
            soft_rst_1    = ($urandom_range(0, 40) == 0);
            soft_rst_2    = ($urandom_range(0, 40) == 0);
            parity_done   = ($urandom_range(0, 4) == 0);
            low_pkt_valid = ($urandom_range(0, 4) == 0);
            @(posedge clk); #1;
            vectors++;
            if ({outs_a, outs_b} !== {exp_out(m_a), exp_out(m_b)}) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b_%b exp=%b_%b", c, outs_a, outs_b, exp_out(m_a), exp_out(m_b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_midpacket();
        test_low_pkt_valid();
        test_wait_empty();
        test_timeout();
        test_soft_reset();
        test_invalid_addr();
        test_async_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
Packet-sequencing controller for the 1x3 router. It decodes the header address and decides when the input register captures header, payload and parity bytes. It throttles the source via busy while the destination FIFO is full or not yet drained, and aborts a packet on destination soft reset or wait timeout. It drives detect_add/write_en_reg into router_sync and the ld/lfd/laf/full/rst_int strobes into the input register block.

Parameters:
WAIT_MAX, 63, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped (1..255)
CNT_W, 8, width of the wait counter; must satisfy 2**CNT_W > WAIT_MAX

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_in  input  1  asynchronous, active-low reset
pkt_valid  input  1  source asserts for the whole header+payload; deasserts with parity byte
data_in  input  2  header address bits [1:0]; 0/1/2 = port, 3 = invalid
fifo_full  input  1  full flag of currently addressed FIFO (from router_sync)
fifo_empty_0  input  1  empty flag of FIFO 0
fifo_empty_1  input  1  empty flag of FIFO 1
fifo_empty_2  input  1  empty flag of FIFO 2
soft_rst_0  input  1  soft reset pulse, FIFO 0
soft_rst_1  input  1  soft reset pulse, FIFO 1
soft_rst_2  input  1  soft reset pulse, FIFO 2
parity_done  input  1  parity byte already stored by the input register block
low_pkt_valid  input  1  pkt_valid fell while FIFO was full (from the input register block)
detect_add  output  1  header present; router_sync latches the address
write_en_reg  output  1  FIFO write permitted this cycle
ld_state  output  1  in LOAD_DATA
lfd_state  output  1  in LOAD_FIRST_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR; clears internal parity regs
busy  output  1  source must hold current byte
drop_pkt  output  1  one-cycle pulse when a packet is aborted (timeout or soft reset)

Behaviour:
- Moore FSM; all outputs except drop_pkt decode combinationally from state. drop_pkt is registered.
- Reset (async, reset_in=0):
  - state=DECODE_ADDRESS, addr_q=0, wait_cnt=0, drop_pkt=0.
  - Outputs therefore: detect_add=1, all others 0.
- addr_q: loaded from data_in when in DECODE_ADDRESS && pkt_valid && data_in!=3. Selects the empty and soft_rst inputs used by all states.
- DECODE_ADDRESS: detect_add=1, busy=0.
  - pkt_valid && data_in!=3 && empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid && data_in!=3 && !empty[data_in] -> WAIT_TILL_EMPTY; wait_cnt cleared.
  - data_in==3 or !pkt_valid -> stay; invalid header is ignored, no drop_pkt.
- LOAD_FIRST_DATA: lfd_state=1, busy=1 -> LOAD_DATA unconditionally. The header is written this cycle.
- LOAD_DATA: ld_state=1, write_en_reg=1, busy=0.
  - fifo_full -> FIFO_FULL_STATE (full takes priority over pkt_valid fall).
  - !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: full_state=1, busy=1, write_en_reg=0. !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL: laf_state=1, busy=1, write_en_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_en_reg=1 -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1. fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: busy=1, write_en_reg=0; wait_cnt increments each cycle.
  - empty[addr_q] -> LOAD_FIRST_DATA (beats timeout on the same cycle).
  - wait_cnt==WAIT_MAX-1 -> DECODE_ADDRESS with drop_pkt=1 next cycle.
  - The counter saturates and never wraps.
- Soft reset override: soft_rst[addr_q]=1 in any state other than DECODE_ADDRESS forces next state DECODE_ADDRESS and drop_pkt=1. Priority is above every other transition. soft_rst of non-addressed ports is ignored.
- Mid-packet async reset returns to DECODE_ADDRESS immediately. No partial-packet recovery.

Decomposition:
- router_pkg holds:
  - the state enum (8 states, 3-bit binary encoding);
  - ADDR_INVALID=2'b11;
  - the shared router address constants used by router_sync.
- No sub-module. The FSM, addr_q and wait_cnt live in one module.

Test Plan:
- Addr 1, FIFO 1 empty, 3 payload bytes then parity -> states DECODE_ADDRESS, LFD, LD x3, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS; busy=1 only in LFD/LOAD_PARITY/CHECK_PARITY_ERROR.
- fifo_full raised during 2nd payload byte, released 4 cycles later -> FIFO_FULL_STATE held 4 cycles with write_en_reg=0, then LAF, then LD.
- pkt_valid falls while full (low_pkt_valid=1) -> FIFO_FULL_STATE, LAF, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
- Addr 2 with fifo_empty_2=0 for 10 cycles, then 1 -> 10 cycles of WAIT_TILL_EMPTY with busy=1, then LFD; drop_pkt stays 0.
- WAIT_MAX=8, FIFO never empties -> return to DECODE_ADDRESS after 8 wait cycles, drop_pkt pulses 1 cycle; soft_rst_0 asserted in LD with addr_q=0 -> DECODE_ADDRESS next cycle, drop_pkt=1.
- Header data_in=3 with pkt_valid=1 -> stays in DECODE_ADDRESS, busy=0, drop_pkt=0. reset_in low in LD -> outputs go to reset values without waiting for a clock edge.
